mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 8-bit memory shared over the Mem_ADDR / Mem_IN / Mem_OUT / write bus.
- Port 0 is the processor; port 1 is the debug/program loader.
- Serialises accesses, grants round-robin, drives the memory strobes from registers, and returns read data with a one-cycle ack pulse.
- Sits between processor/loader and memory inside the top level.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared single-port memory.
// Every output, including the memory strobes, comes straight from a register.
module mem_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_write,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_write,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant
);

    localparam int CNT_W = (MEM_RD_LAT > 0) ? $clog2(MEM_RD_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_RD_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_op_write, w_op_write_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_mem_write, w_mem_write_nxt;
    logic              r_grant, w_grant_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_ack0, w_ack0_nxt;
    logic              r_ack1, w_ack1_nxt;
    logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
    logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;
    logic              w_winner;
    logic              w_any_req;

    // A tie goes to the port that did not own the previous transaction.
    assign w_any_req = p0_req | p1_req;
    assign w_winner  = (p0_req && p1_req) ? ~r_last_grant : p1_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every next-value gets a default first, so no path through the case infers a latch;
        // mem_write and the acks default low so they can only ever be single-cycle pulses.
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_op_write_nxt   = r_op_write;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_write_nxt  = 1'b0;
        w_grant_nxt      = r_grant;
        w_busy_nxt       = r_busy;
        w_ack0_nxt       = 1'b0;
        w_ack1_nxt       = 1'b0;
        w_rdata0_nxt     = r_rdata0;
        w_rdata1_nxt     = r_rdata1;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt      = ACCESS;
                    w_busy_nxt       = 1'b1;
                    w_cnt_nxt        = '0;
                    w_grant_nxt      = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_mem_addr_nxt   = w_winner ? p1_addr  : p0_addr;
                    w_mem_wdata_nxt  = w_winner ? p1_wdata : p0_wdata;
                    w_op_write_nxt   = w_winner ? p1_write : p0_write;
                    w_mem_write_nxt  = w_winner ? p1_write : p0_write;
                end
            end

            ACCESS: begin
                if (r_op_write) begin
                    w_state_nxt = DONE;
                    w_ack0_nxt  = ~r_grant;
                    w_ack1_nxt  = r_grant;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt = DONE;
                    w_ack0_nxt  = ~r_grant;
                    w_ack1_nxt  = r_grant;
                    if (r_grant) begin
                        w_rdata1_nxt = mem_rdata;
                    end else begin
                        w_rdata0_nxt = mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Reset abandons any transaction in flight: strobes and acks clear at once, no ack follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_op_write   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_write  <= 1'b0;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_op_write   <= w_op_write_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_grant      <= w_grant_nxt;
            r_busy       <= w_busy_nxt;
            r_ack0       <= w_ack0_nxt;
            r_ack1       <= w_ack1_nxt;
            r_rdata0     <= w_rdata0_nxt;
            r_rdata1     <= w_rdata1_nxt;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_write = r_mem_write;
    assign busy      = r_busy;
    assign grant     = r_grant;
    assign p0_ack    = r_ack0;
    assign p1_ack    = r_ack1;
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue each transaction as issued, and a monitor
// checks strobes, arbitration order, ack timing and read data against a reference memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int LAT = 1;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       preload = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wd0 = 8'h00, wd1 = 8'h00;
    logic       ack0, ack1, mem_write, busy, grant;
    logic [7:0] rd0, rd1, mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(req0), .p0_addr(addr0), .p0_wdata(wd0), .p0_write(wr0), .p0_ack(ack0), .p0_rdata(rd0),
        .p1_req(req1), .p1_addr(addr1), .p1_wdata(wd1), .p1_write(wr1), .p1_ack(ack1), .p1_rdata(rd1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 7) ^ 8'h5A);
    endfunction

    // Synchronous memory with one edge of read latency.
    logic [7:0] dut_mem [256];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dut_mem[i] <= init_val(i);
        end else if (mem_write) begin
            dut_mem[mem_addr] <= mem_wdata;
        end
        rd_q <= dut_mem[mem_addr];
    end
    assign mem_rdata = rd_q;

    // Reference model and scoreboard state.
    logic [7:0] ref_mem [256];
    txn_t       q0[$], q1[$];
    logic [7:0] exp_rd [2];
    int         n_checks = 0, n_fail = 0;
    logic       tb_last = 1'b1;
    logic       s_req0 = 1'b0, s_req1 = 1'b0;
    logic       exp_own;
    int         bcyc = 0, lastc = 0, idle_cnt = 0;
    logic       have_cur = 1'b0;
    txn_t       cur, popped;
    int         ack_order[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        s_req0 <= req0;
        s_req1 <= req1;
    end

    // Monitor: a transaction occupies 2 busy cycles (write) or LAT+2 (read), ack on the last.
    always @(negedge clk) begin
        if (reset) begin
            bcyc    = 0;
            tb_last = 1'b1;
        end else if (busy) begin
            if (bcyc == 0) begin
                exp_own = (s_req0 && s_req1) ? ~tb_last : s_req1;
                check("grant_owner", 32'(grant), 32'(exp_own));
                tb_last = grant;
                if ((grant ? q1.size() : q0.size()) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_without_request: port %0d granted with nothing queued", grant);
                    have_cur = 1'b0;
                end else begin
                    cur      = grant ? q1[0] : q0[0];
                    have_cur = 1'b1;
                end
            end
            if (have_cur) begin
                lastc = cur.write ? 1 : LAT + 1;
                check("mem_write", 32'(mem_write), 32'(cur.write && bcyc == 0));
                check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                check("ack_owner", 32'(grant ? ack1 : ack0), 32'(bcyc == lastc));
                check("ack_other", 32'(grant ? ack0 : ack1), 32'd0);
                if (bcyc == lastc) begin
                    if (cur.write) ref_mem[cur.addr] = cur.wdata;
                    else exp_rd[grant] = ref_mem[cur.addr];
                    if (grant) popped = q1.pop_front();
                    else popped = q0.pop_front();
                    check("rdata_p0", 32'(rd0), 32'(exp_rd[0]));
                    check("rdata_p1", 32'(rd1), 32'(exp_rd[1]));
                    ack_order.push_back(int'(grant));
                    have_cur = 1'b0;
                end
            end
            bcyc++;
        end else begin
            bcyc = 0;
            idle_cnt++;
            check("idle_quiet", {29'd0, mem_write, ack0, ack1}, 32'd0);
        end
    end

    // mode 0: hold request stable; 1: change address after grant; 2: drop req and scramble after grant.
    task automatic drive(input int port, input logic wr, input logic [7:0] a, input logic [7:0] d, input int mode);
        txn_t t;
        bit   got;
        t = '{write: wr, addr: a, wdata: d};
        @(negedge clk);
        if (port == 0) begin
            wr0 = wr; addr0 = a; wd0 = d; req0 = 1'b1; q0.push_back(t);
        end else begin
            wr1 = wr; addr1 = a; wd1 = d; req1 = 1'b1; q1.push_back(t);
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if ((port == 0) ? ack0 : ack1) begin
                got = 1'b1;
            end else if (mode != 0 && busy && grant == port[0]) begin
                if (port == 0) begin
                    addr0 = a + 8'd1;
                    if (mode == 2) begin req0 = 1'b0; wd0 = ~d; wr0 = ~wr; end
                end else begin
                    addr1 = a + 8'd1;
                    if (mode == 2) begin req1 = 1'b0; wd1 = ~d; wr1 = ~wr; end
                end
            end
        end
        if (port == 0) req0 = 1'b0;
        else req1 = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: port %0d got no ack within 40 cycles", port);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        reset = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_acks", {30'd0, ack0, ack1}, 32'd0);
        check("rst_rdata", {16'd0, rd0, rd1}, 32'd0);
        check("rst_busy_grant", {30'd0, busy, grant}, 32'd0);
        preload = 1'b0;
        reset   = 1'b0;

        // Single write then single read from the other port.
        drive(0, 1'b1, 8'h10, 8'hA5, 0);
        drive(1, 1'b0, 8'h10, 8'h00, 0);
        #1 check("p1_read_0x10", 32'(rd1), 32'hA5);

        // Both ports request continuously: grants alternate starting with port 0.
        pulse_reset();
        ack_order.delete();
        fork
            repeat (3) drive(0, 1'b1, 8'h20, 8'h01, 0);
            repeat (3) drive(1, 1'b1, 8'h21, 8'h02, 0);
        join
        #1 check("rr_count", 32'(ack_order.size()), 32'd6);
        for (int i = 0; i < ack_order.size(); i++) check("rr_order", 32'(ack_order[i]), 32'(i % 2));

        // Port 1 arrives while port 0 is in ACCESS: only one idle cycle between them.
        idle_cnt = 0;
        fork
            drive(0, 1'b1, 8'h50, 8'h3C, 0);
            begin
                @(negedge clk);
                drive(1, 1'b0, 8'h50, 8'h00, 0);
            end
        join
        #1 check("idle_gap", 32'(idle_cnt), 32'd2);
        check("queued_read", 32'(rd1), 32'h3C);

        // Reset while a port 0 write is in ACCESS.
        @(negedge clk);
        wr0 = 1'b1; addr0 = 8'h60; wd0 = 8'h77; req0 = 1'b1;
        q0.push_back('{write: 1'b1, addr: 8'h60, wdata: 8'h77});
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (busy) got = 1'b1;
        end
        check("abort_granted", 32'(got), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", {30'd0, ack0, ack1}, 32'd0);
        req0 = 1'b0;
        q0.delete();
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 8'h10, 8'h00, 0);
        #1 check("read_after_reset", 32'(rd0), 32'hA5);
        drive(0, 1'b0, 8'h60, 8'h00, 0);

        // Address change after grant is ignored.
        drive(0, 1'b1, 8'h30, 8'h5C, 0);
        drive(0, 1'b1, 8'h31, 8'hC3, 0);
        drive(0, 1'b0, 8'h30, 8'h00, 1);
        #1 check("addr_change_rdata", 32'(rd0), 32'h5C);

        // Randomised traffic from both ports over a small, colliding address window.
        fork
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                drive(0, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                drive(1, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
        join
        #1 check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
